// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN key-entry front end.
// Holds the key codes, the operator encodings, the FSM state types and the
// key-code to operator mapping.
package rpn_pkg;

   localparam logic [3:0] KEY_ENTER = 4'd10;
   localparam logic [3:0] KEY_MUL   = 4'd11;
   localparam logic [3:0] KEY_ADD   = 4'd12;
   localparam logic [3:0] KEY_SUB   = 4'd13;
   localparam logic [3:0] KEY_POP   = 4'd14;
   localparam logic [3:0] KEY_CLEAR = 4'd15;

   localparam logic [1:0] OP_MUL = 2'd0;
   localparam logic [1:0] OP_ADD = 2'd1;
   localparam logic [1:0] OP_SUB = 2'd2;

   typedef enum logic {ST_IDLE, ST_ISSUE_OP} cmd_state_t;
   typedef enum logic {DB_WAIT_PRESS, DB_WAIT_RELEASE} db_state_t;

   function automatic logic [1:0] key_to_op(input logic [3:0] code);
      case (code)
         KEY_ADD: key_to_op = OP_ADD;
         KEY_SUB: key_to_op = OP_SUB;
         default: key_to_op = OP_MUL;
      endcase
   endfunction

endpackage

// File: rtl/rpn_key_entry_if.sv
// Control bundle from the key-entry front end to the RPN stack stage.
//   in[7:0]       operand, valid with get_input, held afterwards
//   operator[1:0] operation, valid with get_operator, held afterwards
//   get_input     one-cycle push pulse
//   get_operator  one-cycle operate pulse
//   pop           one-cycle pop pulse
//   delete        one-cycle clear-stack pulse
// master: key-entry side (drives), slave: stack side (receives).
interface rpn_key_entry_if;
   logic [7:0] in;
   logic [1:0] operator;
   logic       get_input;
   logic       get_operator;
   logic       pop;
   logic       delete;

   modport master (output in, output operator, output get_input,
                   output get_operator, output pop, output delete);
   modport slave  (input in, input operator, input get_input,
                   input get_operator, input pop, input delete);
endinterface

// File: rtl/key_debounce.sv
// Synchronises the raw key_valid level and debounces press and release.
// A press is accepted after DB_CYCLES consecutive synced 1 samples; the next
// press is armed only after DB_CYCLES consecutive synced 0 samples.
// Ports: clk, rst_n, key_valid (raw level), accept (one-cycle strobe).
module key_debounce
   import rpn_pkg::*;
#(
   parameter int DB_CYCLES = 16,
   parameter int DB_W      = $clog2(DB_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_valid,
   output logic accept
);

   logic [1:0]      sync_q;
   logic [DB_W-1:0] cnt;
   db_state_t       state;
   logic            level_ok;

   // The level being qualified depends on which edge we are waiting for.
   assign level_ok = (state == DB_WAIT_RELEASE) ? ~sync_q[1] : sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
         cnt    <= '0;
         state  <= DB_WAIT_PRESS;
         accept <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], key_valid};
         accept <= 1'b0;
         if (!level_ok) begin
            cnt <= '0;
         end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
            cnt <= '0;
            if (state == DB_WAIT_PRESS) begin
               state  <= DB_WAIT_RELEASE;
               accept <= 1'b1;
            end else begin
               state <= DB_WAIT_PRESS;
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/rpn_key_entry.sv
// RPN keypad front end: debounces key presses, accumulates decimal digits
// into an 8-bit operand and issues one stack command per accepted key.
// Ports: clk, rst_n, key_valid/key_code (raw keypad), stk (master side of
// rpn_key_entry_if), entry_val/entry_active/entry_ovf (display status).
// Build option: RPN_BACKSPACE_EN turns POP on an active entry into backspace.
//
// state       | meaning
// ST_IDLE     | waiting for an accepted key
// ST_ISSUE_OP | implicit push just issued, operate pulse follows
module rpn_key_entry
   import rpn_pkg::*;
#(
   parameter int DB_CYCLES = 16,
   parameter int DB_W      = $clog2(DB_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_valid,
   input  logic [3:0]       key_code,
   rpn_key_entry_if.master  stk,
   output logic [7:0]       entry_val,
   output logic             entry_active,
   output logic             entry_ovf
);

   logic accept;

   key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .accept    (accept)
   );

   cmd_state_t state, state_nxt;
   logic [7:0]  in_nxt, val_nxt;
   logic [1:0]  op_nxt;
   logic        gi_nxt, go_nxt, pop_nxt, del_nxt, act_nxt, ovf_nxt;
   logic [11:0] prod;
`ifdef RPN_BACKSPACE_EN
   logic [7:0]  quo;
   assign quo = entry_val / 8'd10;
`endif

   // Widened so the overflow test sees the untruncated value.
   assign prod = {4'b0000, entry_val} * 12'd10 + {8'h00, key_code};

   always_comb begin
      state_nxt = state;
      in_nxt    = stk.in;
      op_nxt    = stk.operator;
      val_nxt   = entry_val;
      act_nxt   = entry_active;
      ovf_nxt   = entry_ovf;
      gi_nxt    = 1'b0;
      go_nxt    = 1'b0;
      pop_nxt   = 1'b0;
      del_nxt   = 1'b0;
      case (state)
         ST_ISSUE_OP: begin
            go_nxt    = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            if (accept) begin
               if (key_code < KEY_ENTER) begin
                  if (prod <= 12'd255) begin
                     val_nxt = prod[7:0];
                     act_nxt = 1'b1;
                  end else begin
                     ovf_nxt = 1'b1;
                  end
               end else if (key_code == KEY_ENTER || key_code == KEY_MUL ||
                            key_code == KEY_ADD   || key_code == KEY_SUB) begin
                  if (key_code != KEY_ENTER) op_nxt = key_to_op(key_code);
                  if (entry_active) begin
                     in_nxt  = entry_val;
                     gi_nxt  = 1'b1;
                     val_nxt = 8'h00;
                     act_nxt = 1'b0;
                     ovf_nxt = 1'b0;
                     if (key_code != KEY_ENTER) state_nxt = ST_ISSUE_OP;
                  end else if (key_code != KEY_ENTER) begin
                     go_nxt = 1'b1;
                  end
               end else if (key_code == KEY_POP) begin
`ifdef RPN_BACKSPACE_EN
                  if (entry_active) begin
                     val_nxt = quo;
                     ovf_nxt = 1'b0;
                     act_nxt = (quo != 8'h00) || (entry_val >= 8'd10);
                  end else begin
                     pop_nxt = 1'b1;
                  end
`else
                  pop_nxt = 1'b1;
`endif
               end else begin
                  del_nxt = 1'b1;
                  val_nxt = 8'h00;
                  act_nxt = 1'b0;
                  ovf_nxt = 1'b0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= ST_IDLE;
         stk.in           <= 8'h00;
         stk.operator     <= 2'b00;
         stk.get_input    <= 1'b0;
         stk.get_operator <= 1'b0;
         stk.pop          <= 1'b0;
         stk.delete       <= 1'b0;
         entry_val        <= 8'h00;
         entry_active     <= 1'b0;
         entry_ovf        <= 1'b0;
      end else begin
         state            <= state_nxt;
         stk.in           <= in_nxt;
         stk.operator     <= op_nxt;
         stk.get_input    <= gi_nxt;
         stk.get_operator <= go_nxt;
         stk.pop          <= pop_nxt;
         stk.delete       <= del_nxt;
         entry_val        <= val_nxt;
         entry_active     <= act_nxt;
         entry_ovf        <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_rpn_key_entry.sv
// Testbench for rpn_key_entry: directed key sequences, bouncing and long
// holds, random key streams checked against a behavioural entry model, and
// an asynchronous reset in the cycle between implicit push and operate.
module tb_rpn_key_entry;

   localparam int DB = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'd0;
   logic [7:0] entry_val;
   logic       entry_active, entry_ovf;

   rpn_key_entry_if stk ();

   rpn_key_entry #(.DB_CYCLES(DB)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .stk          (stk),
      .entry_val    (entry_val),
      .entry_active (entry_active),
      .entry_ovf    (entry_ovf)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Pulse monitor, sampled on the inactive edge.
   int cyc = 0, n_gi = 0, n_go = 0, n_pop = 0, n_del = 0, n_multi = 0;
   int gi_cyc = 0, go_cyc = 0;
   logic [7:0] seen_in = 8'h00;
   logic [1:0] seen_op = 2'b00;

   always @(negedge clk) begin
      cyc++;
      if (stk.get_input)    begin n_gi++;  gi_cyc = cyc; seen_in = stk.in; end
      if (stk.get_operator) begin n_go++;  go_cyc = cyc; seen_op = stk.operator; end
      if (stk.pop)    n_pop++;
      if (stk.delete) n_del++;
      if ((32'(stk.get_input) + 32'(stk.get_operator) + 32'(stk.pop) +
           32'(stk.delete)) > 1) n_multi++;
   end

   // Reference model of the typed entry and the held stack outputs.
   int m_ev = 0, m_in = 0, m_op = 0;
   bit m_act = 0, m_ovf = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input int code, input int hold, input bit bouncy);
      int b_gi, b_go, b_pop, b_del, e_gi, e_go, e_pop, e_del, nv;
      b_gi = n_gi; b_go = n_go; b_pop = n_pop; b_del = n_del;
      e_gi = 0; e_go = 0; e_pop = 0; e_del = 0;
      key_code = 4'(code);
      if (bouncy) begin
         repeat ($urandom_range(2, 5)) begin
            key_valid = 1'b1; tick($urandom_range(1, DB - 4));
            key_valid = 1'b0; tick($urandom_range(1, 3));
         end
      end
      key_valid = 1'b1;
      tick(hold);
      key_valid = 1'b0;
      if (bouncy) begin
         repeat ($urandom_range(2, 5)) begin
            tick($urandom_range(1, DB - 4));
            key_valid = 1'b1; tick($urandom_range(1, 3));
            key_valid = 1'b0;
         end
      end
      tick(DB + 6);

      if (code < 10) begin
         nv = m_ev * 10 + code;
         if (nv <= 255) begin m_ev = nv; m_act = 1; end
         else m_ovf = 1;
      end else if (code <= 13) begin
         if (code != 10) m_op = code - 11;
         if (m_act) begin
            e_gi = 1; m_in = m_ev; m_ev = 0; m_act = 0; m_ovf = 0;
         end
         if (code != 10) e_go = 1;
      end else if (code == 14) begin
`ifdef RPN_BACKSPACE_EN
         if (m_act) begin
            nv = m_ev / 10;
            m_act = (nv != 0) || (m_ev >= 10);
            m_ev = nv; m_ovf = 0;
         end else e_pop = 1;
`else
         e_pop = 1;
`endif
      end else begin
         e_del = 1; m_ev = 0; m_act = 0; m_ovf = 0;
      end

      chk($sformatf("get_input count key %0d", code), n_gi - b_gi, e_gi);
      chk($sformatf("get_operator count key %0d", code), n_go - b_go, e_go);
      chk($sformatf("pop count key %0d", code), n_pop - b_pop, e_pop);
      chk($sformatf("delete count key %0d", code), n_del - b_del, e_del);
      if (e_gi == 1 && n_gi - b_gi == 1) chk("in at push", seen_in, m_in);
      if (e_go == 1 && n_go - b_go == 1) chk("operator at operate", seen_op, m_op);
      if (e_gi == 1 && e_go == 1) chk("push then operate spacing", go_cyc - gi_cyc, 1);
      chk("in held", stk.in, m_in);
      chk("operator held", stk.operator, m_op);
      chk("entry_val", entry_val, m_ev);
      chk("entry_active", entry_active, m_act);
      chk("entry_ovf", entry_ovf, m_ovf);
   endtask

   initial begin
      int seq [];
      int b_go, found;

      tick(3);
      chk("reset entry_val", entry_val, 0);
      chk("reset get_input", stk.get_input, 0);
      chk("reset in", stk.in, 0);
      rst_n = 1'b1;
      tick(3);
      chk("post-reset entry_active", entry_active, 0);
      chk("post-reset entry_ovf", entry_ovf, 0);

      // Directed sequences: digits, overflow, implicit push, clear, pop.
      seq = '{1, 2, 3, 10, 2, 5, 6, 10, 7, 12, 4, 5, 15, 4, 5, 14, 14, 14,
              11, 13, 9, 9, 11, 10, 14};
      foreach (seq[i]) press(seq[i], DB + 4, 1'b0);

      // Bouncing contacts and a very long hold still give one command each.
      press(8, DB + 6, 1'b1);
      press(3, DB + 6, 1'b1);
      press(1, 10 * DB, 1'b0);
      press(10, 10 * DB, 1'b1);

      // Random key stream.
      repeat (70) begin
         int k;
         k = ($urandom_range(0, 2) != 0) ? $urandom_range(0, 9) : $urandom_range(10, 15);
         press(k, $urandom_range(DB + 4, 3 * DB), 1'($urandom_range(0, 1)));
      end

      // Reset in the ISSUE_OP cycle drops the pending operate pulse.
      press(7, DB + 4, 1'b0);
      key_code = 4'd12;
      key_valid = 1'b1;
      found = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (stk.get_input) begin found = 1; break; end
      end
      chk("implicit push seen before reset", found, 1);
      b_go = n_go;
      #1 rst_n = 1'b0;
      #1;
      chk("async reset get_input", stk.get_input, 0);
      chk("async reset in", stk.in, 0);
      chk("async reset operator", stk.operator, 0);
      chk("async reset entry_val", entry_val, 0);
      key_valid = 1'b0;
      tick(4);
      rst_n = 1'b1;
      tick(DB + 10);
      chk("no operate after reset", n_go - b_go, 0);
      m_ev = 0; m_act = 0; m_ovf = 0; m_in = 0; m_op = 0;
      press(4, DB + 4, 1'b0);
      press(11, DB + 4, 1'b0);

      chk("never two pulses at once", n_multi, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
